// File: rtl/nios_system_ledr_sequencer_if.sv
// nios_system_ledr_sequencer_if
//   Avalon-MM slave bus for the LED sequencer: 2-bit word address,
//   chipselect-qualified active-low write strobe, 32-bit write data and a
//   zero-wait-state combinational read data return.
//   master modport: driven by the bus fabric / CPU side.
//   slave  modport: used by the sequencer.
interface nios_system_ledr_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_ledr_sequencer.sv
// nios_system_ledr_sequencer
//   Drop-in replacement for the LEDR output PIO that animates the LEDs in
//   hardware. Software loads PATTERN, PERIOD and CONTROL; the block then
//   steps out_port every PERIOD+1 cycles in static, blink, rotate-left or
//   bounce mode.
//
//   Registers (word address):
//     0 PATTERN  [WIDTH-1:0]  write reloads out_port, dir=left, phase=on
//     1 CONTROL  bit0 run, bits[2:1] mode, bit3 irq_en
//     2 PERIOD   [CNT_W-1:0]  step interval is PERIOD+1 cycles
//     3 STATUS   [WIDTH-1:0] out_port, bit30 dir (1=right), bit31 step flag;
//                write with bit31=1 clears the flag
//
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     bus            Avalon-MM slave (nios_system_ledr_sequencer_if.slave)
//     out_port       registered LED drive
//     irq            flag & irq_en (only when LEDR_SEQ_IRQ_EN is defined)
//
//   Build option: define LEDR_SEQ_IRQ_EN to add the irq port and make
//   CONTROL bit3 writable. Without it CONTROL bit3 reads 0 and the flag is
//   only visible by polling STATUS.
module nios_system_ledr_sequencer #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    nios_system_ledr_sequencer_if.slave bus,
    output logic [WIDTH-1:0]           out_port
`ifdef LEDR_SEQ_IRQ_EN
    ,
    output logic                       irq
`endif
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTL   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             run;
    mode_e            mode;
    logic             dir;     // 0 = moving left, 1 = moving right
    logic             phase;   // blink: 1 = pattern shown
    logic             flag;
`ifdef LEDR_SEQ_IRQ_EN
    logic             irq_en;
`endif

    logic             wr;
    logic             pat_wr, ctrl_wr, per_wr, stat_wr;
    logic             run_rise;
    logic             step;
    logic             step_taken;
    logic [WIDTH-1:0] step_out;
    logic             step_dir;
    logic             step_phase;
    logic             ien_rd;

    // Write data bits beyond the implemented register fields are ignored.
    logic             unused_wd;
    assign unused_wd = ^bus.writedata;

    assign wr      = bus.chipselect && !bus.write_n;
    assign pat_wr  = wr && (bus.address == 2'd0);
    assign ctrl_wr = wr && (bus.address == 2'd1);
    assign per_wr  = wr && (bus.address == 2'd2);
    assign stat_wr = wr && (bus.address == 2'd3);

    assign run_rise   = ctrl_wr && bus.writedata[0] && !run;
    assign step       = run && (cnt == '0);
    // A PATTERN write on a step edge takes precedence; that step is dropped.
    assign step_taken = step && !pat_wr;

`ifdef LEDR_SEQ_IRQ_EN
    assign ien_rd = irq_en;
    assign irq    = flag & irq_en;
`else
    assign ien_rd = 1'b0;
`endif

    // Next LED state for a step in the current mode.
    always_comb begin
        step_out   = out_port;
        step_dir   = dir;
        step_phase = phase;
        case (mode)
            MODE_STATIC: step_out = pattern;
            MODE_BLINK: begin
                step_phase = !phase;
                step_out   = !phase ? pattern : '0;
            end
            MODE_ROTL: step_out = {out_port[WIDTH-2:0], out_port[WIDTH-1]};
            MODE_BOUNCE: begin
                // Reverse on hitting an end; the turn-around step already
                // moves one position in the new direction.
                if (!dir) begin
                    if (out_port[WIDTH-1]) begin
                        step_dir = 1'b1;
                        step_out = out_port >> 1;
                    end else begin
                        step_out = out_port << 1;
                    end
                end else begin
                    if (out_port[0]) begin
                        step_dir = 1'b0;
                        step_out = out_port << 1;
                    end else begin
                        step_out = out_port >> 1;
                    end
                end
            end
            default: step_out = out_port;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern  <= '0;
            out_port <= '0;
            period   <= '0;
            cnt      <= '0;
            run      <= 1'b0;
            mode     <= MODE_STATIC;
            dir      <= 1'b0;
            phase    <= 1'b0;
            flag     <= 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
            irq_en   <= 1'b0;
`endif
        end else begin
            if (ctrl_wr) begin
                run  <= bus.writedata[0];
                mode <= mode_e'(bus.writedata[2:1]);
`ifdef LEDR_SEQ_IRQ_EN
                irq_en <= bus.writedata[3];
`endif
            end

            // PERIOD only lands in the counter at the next reload.
            if (per_wr)
                period <= bus.writedata[CNT_W-1:0];

            if (pat_wr || run_rise || step)
                cnt <= period;
            else if (run)
                cnt <= cnt - CNT_W'(1);

            if (pat_wr) begin
                pattern  <= bus.writedata[WIDTH-1:0];
                out_port <= bus.writedata[WIDTH-1:0];
                dir      <= 1'b0;
                phase    <= 1'b1;
            end else if (step) begin
                out_port <= step_out;
                dir      <= step_dir;
                phase    <= step_phase;
            end

            // Setting wins over a simultaneous clear.
            if (step_taken)
                flag <= 1'b1;
            else if (stat_wr && bus.writedata[31])
                flag <= 1'b0;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata[WIDTH-1:0] = pattern;
            2'd1: bus.readdata[3:0] = {ien_rd, mode, run};
            2'd2: bus.readdata[CNT_W-1:0] = period;
            2'd3: begin
                bus.readdata[WIDTH-1:0] = out_port;
                bus.readdata[30]        = dir;
                bus.readdata[31]        = flag;
            end
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_ledr_sequencer.sv
// Randomized bench for nios_system_ledr_sequencer. A driver issues random
// bus traffic each cycle, advances a behavioural model of the register set
// and pushes the expected LED/readdata/irq values; a monitor on the falling
// edge pops and compares them.
module tb_nios_system_ledr_sequencer;
    localparam int          W     = 18;
    localparam int          CW    = 24;
    localparam int unsigned MASK  = (1 << W) - 1;
    localparam int unsigned PMASK = (1 << CW) - 1;
    localparam int          NCYC  = 4000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_system_ledr_sequencer_if bus();
    logic [W-1:0] out_port;
`ifdef LEDR_SEQ_IRQ_EN
    logic irq;
`endif

    nios_system_ledr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
`ifdef LEDR_SEQ_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    typedef struct {
        logic [31:0] out;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model state: plain integers describing what software would observe.
    int unsigned m_pat, m_out, m_per, m_wait;  // m_wait: cycles left before next step
    int unsigned m_mode;
    bit          m_run, m_left_done, m_dir, m_on, m_flag, m_ien;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_pat = 0; m_out = 0; m_per = 0; m_wait = 0; m_mode = 0;
        m_run = 0; m_dir = 0; m_on = 0; m_flag = 0; m_ien = 0;
    endfunction

    function automatic int unsigned advance(input int unsigned o);
        int unsigned r;
        r = o;
        case (m_mode)
            0: r = m_pat;
            1: begin m_on = !m_on; r = m_on ? m_pat : 0; end
            2: r = ((o << 1) | (o >> (W - 1))) & MASK;
            default: begin
                if (m_dir == 0) begin
                    if (o >= (1 << (W - 1))) begin m_dir = 1; r = o / 2; end
                    else r = (o * 2) & MASK;
                end else begin
                    if (o % 2 == 1) begin m_dir = 0; r = (o * 2) & MASK; end
                    else r = o / 2;
                end
            end
        endcase
        return r;
    endfunction

    // Apply one clock edge using the bus inputs that were presented to it.
    function automatic void model_edge();
        bit          wr, stepped, pw, old_run;
        int unsigned wd, a, old_per;
        wr      = bus.chipselect && !bus.write_n;
        wd      = bus.writedata;
        a       = bus.address;
        pw      = wr && a == 0;
        old_run = m_run;
        old_per = m_per;
        stepped = 0;
        if (pw) begin
            m_pat = wd & MASK; m_out = m_pat; m_dir = 0; m_on = 1; m_wait = old_per;
        end else if (m_run && m_wait == 0) begin
            m_out = advance(m_out); m_wait = old_per; m_flag = 1; stepped = 1;
        end else if (m_run) begin
            m_wait = m_wait - 1;
        end
        if (wr && a == 1) begin
            m_run  = wd[0];
            m_mode = (wd >> 1) & 3;
`ifdef LEDR_SEQ_IRQ_EN
            m_ien  = wd[3];
`endif
            if (!old_run && m_run) m_wait = old_per;
        end
        if (wr && a == 2) m_per = wd & PMASK;
        if (wr && a == 3 && wd[31] && !stepped) m_flag = 0;
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned a);
        case (a)
            0: return m_pat;
            1: return {28'd0, m_ien, m_mode[1:0], m_run};
            2: return m_per;
            default: return {m_flag, m_dir, 12'd0, m_out[W-1:0]};
        endcase
    endfunction

    function automatic int unsigned rand_pattern();
        case ($urandom_range(0, 5))
            0: return 1 << $urandom_range(0, W - 1);
            1: return 32'h20001;
            2: return MASK;
            3: return 0;
            default: return $urandom & MASK;
        endcase
    endfunction

    task automatic drive_random();
        int r;
        r = $urandom_range(0, 99);
        bus.address    = 2'($urandom_range(0, 3));
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = $urandom;
        if (r < 5) begin
            // write strobe without chipselect must be ignored
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b0;
        end else if (r < 55) begin
            bus.chipselect = 1'($urandom_range(0, 1));
        end else begin
            bus.write_n = 1'b0;
            if (r < 65) begin
                bus.address = 2'd0; bus.writedata = rand_pattern() | ($urandom & ~MASK);
            end else if (r < 75) begin
                bus.address = 2'd1;
                bus.writedata = {$urandom_range(0, 15) << 4, 1'($urandom_range(0, 1)),
                                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
            end else if (r < 83) begin
                bus.address = 2'd2;
                bus.writedata = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 30)
                                                             : $urandom_range(0, 4);
            end else begin
                bus.address = 2'd3;
            end
        end
    endtask

    // Monitor: compare whatever expectation the driver queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("out_port", 32'(out_port), e.out);
            check("readdata", bus.readdata, e.rd);
`ifdef LEDR_SEQ_IRQ_EN
            check("irq", 32'(irq), 32'(e.irq));
`endif
        end
    end

    initial begin
        exp_t e;
        int   waited;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        model_reset();
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            if (reset_n) model_edge();
            else model_reset();
            if (i == NCYC / 2) reset_n = 1'b0;
            if (i == 3 || i == NCYC / 2 + 3) reset_n = 1'b1;
            if (!reset_n) model_reset();
            drive_random();
            // reset checks: cycle through all addresses while held in reset
            if (!reset_n) bus.address = 2'(i);
            e.out = m_out;
            e.rd  = model_rd(bus.address);
            e.irq = m_flag & m_ien;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
